// File: rtl/id_ex_dump.sv
// Snapshots the ID/EX pipeline latch on request and streams it as a framed,
// XOR-checksummed byte sequence to a UART transmitter over a valid/ready port.
module id_ex_dump #(
   parameter int BUS_SIZE = 32
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_start,
   input  logic [2:0]          i_mem_rd_src,
   input  logic [1:0]          i_mem_wr_src,
   input  logic                i_mem_write,
   input  logic                i_wb,
   input  logic                i_mem_to_reg,
   input  logic [1:0]          i_reg_dst,
   input  logic                i_alu_src_a,
   input  logic [1:0]          i_alu_src_b,
   input  logic [2:0]          i_alu_op,
   input  logic [BUS_SIZE-1:0] i_bus_a,
   input  logic [BUS_SIZE-1:0] i_bus_b,
   input  logic [4:0]          i_rs,
   input  logic [4:0]          i_rt,
   input  logic [4:0]          i_rd,
   input  logic [5:0]          i_funct,
   input  logic [BUS_SIZE-1:0] i_shamt_ext_unsigned,
   input  logic [BUS_SIZE-1:0] i_inm_ext_signed,
   input  logic [BUS_SIZE-1:0] i_inm_upp,
   input  logic [BUS_SIZE-1:0] i_inm_ext_unsigned,
   output logic [7:0]          o_tx_data,
   output logic                o_tx_valid,
   input  logic                i_tx_ready,
   output logic                o_busy,
   output logic                o_done
);

   localparam int B         = BUS_SIZE / 8;
   localparam int FRAME_LEN = 8 + 6 * B;
   localparam int IDX_W     = $clog2(FRAME_LEN);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
   localparam int REG_BASE  = 3 + 2 * B;
   localparam int IMM_BASE  = 7 + 2 * B;

   typedef enum logic {
      IDLE,
      SEND
   } state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [7:0]          chk_q, chk_d;
   logic                done_q, done_d;
   logic [15:0]         ctrl_q, ctrl_d;
   logic [BUS_SIZE-1:0] bus_a_q, bus_a_d;
   logic [BUS_SIZE-1:0] bus_b_q, bus_b_d;
   logic [4:0]          rs_q, rs_d;
   logic [4:0]          rt_q, rt_d;
   logic [4:0]          rd_q, rd_d;
   logic [5:0]          funct_q, funct_d;
   logic [BUS_SIZE-1:0] shamt_q, shamt_d;
   logic [BUS_SIZE-1:0] inm_s_q, inm_s_d;
   logic [BUS_SIZE-1:0] inm_upp_q, inm_upp_d;
   logic [BUS_SIZE-1:0] inm_u_q, inm_u_d;

   logic [7:0] frame [FRAME_LEN];
   logic [7:0] cur_byte;

   // Frame layout over the snapshot; the trailing byte is the running checksum.
   always_comb begin
      for (int i = 0; i < FRAME_LEN; i++) frame[i] = 8'h00;
      frame[0] = 8'hA5;
      frame[1] = ctrl_q[15:8];
      frame[2] = ctrl_q[7:0];
      for (int i = 0; i < B; i++) begin
         frame[3 + i]            = bus_a_q[BUS_SIZE-1-8*i -: 8];
         frame[3 + B + i]        = bus_b_q[BUS_SIZE-1-8*i -: 8];
         frame[IMM_BASE + i]     = shamt_q[BUS_SIZE-1-8*i -: 8];
         frame[IMM_BASE + B + i] = inm_s_q[BUS_SIZE-1-8*i -: 8];
         frame[IMM_BASE + 2*B + i] = inm_upp_q[BUS_SIZE-1-8*i -: 8];
         frame[IMM_BASE + 3*B + i] = inm_u_q[BUS_SIZE-1-8*i -: 8];
      end
      frame[REG_BASE]     = {3'b000, rs_q};
      frame[REG_BASE + 1] = {3'b000, rt_q};
      frame[REG_BASE + 2] = {3'b000, rd_q};
      frame[REG_BASE + 3] = {2'b00, funct_q};
      frame[FRAME_LEN-1]  = chk_q;
   end

   assign cur_byte = frame[idx_q];

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      chk_d     = chk_q;
      done_d    = 1'b0;
      ctrl_d    = ctrl_q;
      bus_a_d   = bus_a_q;
      bus_b_d   = bus_b_q;
      rs_d      = rs_q;
      rt_d      = rt_q;
      rd_d      = rd_q;
      funct_d   = funct_q;
      shamt_d   = shamt_q;
      inm_s_d   = inm_s_q;
      inm_upp_d = inm_upp_q;
      inm_u_d   = inm_u_q;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               state_d   = SEND;
               idx_d     = '0;
               chk_d     = 8'h00;
               ctrl_d    = {i_mem_rd_src, i_mem_wr_src, i_mem_write, i_wb, i_mem_to_reg,
                            i_reg_dst, i_alu_src_a, i_alu_src_b, i_alu_op};
               bus_a_d   = i_bus_a;
               bus_b_d   = i_bus_b;
               rs_d      = i_rs;
               rt_d      = i_rt;
               rd_d      = i_rd;
               funct_d   = i_funct;
               shamt_d   = i_shamt_ext_unsigned;
               inm_s_d   = i_inm_ext_signed;
               inm_upp_d = i_inm_upp;
               inm_u_d   = i_inm_ext_unsigned;
            end
         end
         SEND: begin
            if (i_tx_ready) begin
               // Header stays out of the checksum; folding in the checksum byte itself is harmless.
               if (idx_q != '0) chk_d = chk_q ^ cur_byte;
               if (idx_q == LAST_IDX) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         chk_q     <= 8'h00;
         done_q    <= 1'b0;
         ctrl_q    <= '0;
         bus_a_q   <= '0;
         bus_b_q   <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         rd_q      <= '0;
         funct_q   <= '0;
         shamt_q   <= '0;
         inm_s_q   <= '0;
         inm_upp_q <= '0;
         inm_u_q   <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         chk_q     <= chk_d;
         done_q    <= done_d;
         ctrl_q    <= ctrl_d;
         bus_a_q   <= bus_a_d;
         bus_b_q   <= bus_b_d;
         rs_q      <= rs_d;
         rt_q      <= rt_d;
         rd_q      <= rd_d;
         funct_q   <= funct_d;
         shamt_q   <= shamt_d;
         inm_s_q   <= inm_s_d;
         inm_upp_q <= inm_upp_d;
         inm_u_q   <= inm_u_d;
      end
   end

   assign o_tx_valid = (state_q == SEND);
   assign o_busy     = (state_q == SEND);
   assign o_tx_data  = o_tx_valid ? cur_byte : 8'h00;
   assign o_done     = done_q;

endmodule

// File: tb/tb_id_ex_dump.sv
// Scoreboard bench for id_ex_dump: expected frames are queued at each start
// request and consumed byte by byte as the DUT hands them to the transmitter.
module tb_id_ex_dump;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_start;
   logic [2:0]  i_mem_rd_src;
   logic [1:0]  i_mem_wr_src;
   logic        i_mem_write;
   logic        i_wb;
   logic        i_mem_to_reg;
   logic [1:0]  i_reg_dst;
   logic        i_alu_src_a;
   logic [1:0]  i_alu_src_b;
   logic [2:0]  i_alu_op;
   logic [31:0] i_bus_a, i_bus_b;
   logic [4:0]  i_rs, i_rt, i_rd;
   logic [5:0]  i_funct;
   logic [31:0] i_shamt_ext_unsigned, i_inm_ext_signed, i_inm_upp, i_inm_ext_unsigned;
   logic [7:0]  o_tx_data;
   logic        o_tx_valid;
   logic        i_tx_ready;
   logic        o_busy;
   logic        o_done;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } exp_t;

   exp_t       sb[$];
   int         n_checks = 0;
   int         n_errors = 0;
   int         xfer_cnt = 0;
   int         pos      = 0;
   logic       done_exp = 1'b0;
   logic [7:0] last_byte = 8'h00;
   logic       rdy_rand = 1'b0;

   id_ex_dump #(.BUS_SIZE(32)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
      .i_mem_rd_src(i_mem_rd_src), .i_mem_wr_src(i_mem_wr_src), .i_mem_write(i_mem_write),
      .i_wb(i_wb), .i_mem_to_reg(i_mem_to_reg), .i_reg_dst(i_reg_dst),
      .i_alu_src_a(i_alu_src_a), .i_alu_src_b(i_alu_src_b), .i_alu_op(i_alu_op),
      .i_bus_a(i_bus_a), .i_bus_b(i_bus_b),
      .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_funct(i_funct),
      .i_shamt_ext_unsigned(i_shamt_ext_unsigned), .i_inm_ext_signed(i_inm_ext_signed),
      .i_inm_upp(i_inm_upp), .i_inm_ext_unsigned(i_inm_ext_unsigned),
      .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
      .o_busy(o_busy), .o_done(o_done)
   );

   always #5 i_clk = ~i_clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cycle();
      @(posedge i_clk);
      #1;
      if (rdy_rand) i_tx_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic clear_inputs();
      i_mem_rd_src = '0; i_mem_wr_src = '0; i_mem_write = 0; i_wb = 0; i_mem_to_reg = 0;
      i_reg_dst = '0; i_alu_src_a = 0; i_alu_src_b = '0; i_alu_op = '0;
      i_bus_a = '0; i_bus_b = '0; i_rs = '0; i_rt = '0; i_rd = '0; i_funct = '0;
      i_shamt_ext_unsigned = '0; i_inm_ext_signed = '0; i_inm_upp = '0; i_inm_ext_unsigned = '0;
   endtask

   task automatic random_inputs();
      i_mem_rd_src = 3'($urandom); i_mem_wr_src = 2'($urandom); i_mem_write = 1'($urandom);
      i_wb = 1'($urandom); i_mem_to_reg = 1'($urandom); i_reg_dst = 2'($urandom);
      i_alu_src_a = 1'($urandom); i_alu_src_b = 2'($urandom); i_alu_op = 3'($urandom);
      i_bus_a = $urandom; i_bus_b = $urandom; i_rs = 5'($urandom); i_rt = 5'($urandom);
      i_rd = 5'($urandom); i_funct = 6'($urandom);
      i_shamt_ext_unsigned = $urandom; i_inm_ext_signed = $urandom;
      i_inm_upp = $urandom; i_inm_ext_unsigned = $urandom;
   endtask

   // Reference frame built straight from the byte layout of the dump format.
   task automatic push_frame();
      logic [7:0]  b[$];
      logic [15:0] c;
      logic [31:0] w[4];
      logic [7:0]  x;
      exp_t        e;
      c = {i_mem_rd_src, i_mem_wr_src, i_mem_write, i_wb, i_mem_to_reg,
           i_reg_dst, i_alu_src_a, i_alu_src_b, i_alu_op};
      b.push_back(c[15:8]);
      b.push_back(c[7:0]);
      for (int i = 3; i >= 0; i--) b.push_back(i_bus_a[8*i +: 8]);
      for (int i = 3; i >= 0; i--) b.push_back(i_bus_b[8*i +: 8]);
      b.push_back({3'b000, i_rs});
      b.push_back({3'b000, i_rt});
      b.push_back({3'b000, i_rd});
      b.push_back({2'b00, i_funct});
      w[0] = i_shamt_ext_unsigned; w[1] = i_inm_ext_signed;
      w[2] = i_inm_upp;            w[3] = i_inm_ext_unsigned;
      for (int k = 0; k < 4; k++)
         for (int i = 3; i >= 0; i--) b.push_back(w[k][8*i +: 8]);
      x = 8'h00;
      foreach (b[i]) x ^= b[i];
      e.data = 8'hA5; e.last = 1'b0; sb.push_back(e);
      foreach (b[i]) begin
         e.data = b[i]; e.last = 1'b0; sb.push_back(e);
      end
      e.data = x; e.last = 1'b1; sb.push_back(e);
   endtask

   task automatic start_frame();
      i_start = 1'b1;
      push_frame();
      cycle();
      i_start = 1'b0;
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 400; k++) begin
         if (!o_busy && sb.size() == 0) break;
         cycle();
      end
      check_eq("frame_timeout_busy", o_busy, 0);
      check_eq("frame_bytes_missing", sb.size(), 0);
   endtask

   task automatic wait_bytes(input int base, input int n);
      for (int k = 0; k < 400; k++) begin
         if (xfer_cnt - base >= n) break;
         cycle();
      end
      check_eq("wait_bytes_timeout", xfer_cnt - base, n);
   endtask

   // Monitor: sampled mid-cycle, so a valid&ready seen here transfers on the next rising edge.
   always @(negedge i_clk) begin
      exp_t e;
      if (i_reset) begin
         sb.delete();
         pos      = 0;
         done_exp = 1'b0;
      end else begin
         check_eq("done_pulse", o_done, done_exp);
         done_exp = 1'b0;
         if (!o_tx_valid) begin
            check_eq("idle_data", o_tx_data, 0);
         end else if (sb.size() == 0) begin
            check_eq("spurious_valid", o_tx_valid, 0);
         end else if (i_tx_ready) begin
            e = sb.pop_front();
            check_eq($sformatf("byte%0d", pos), o_tx_data, e.data);
            last_byte = o_tx_data;
            xfer_cnt++;
            pos = e.last ? 0 : pos + 1;
            if (e.last) done_exp = 1'b1;
         end else begin
            check_eq($sformatf("hold_byte%0d", pos), o_tx_data, sb[0].data);
         end
      end
   end

   initial begin
      int base;
      int n;
      i_reset = 1'b1; i_start = 1'b0; i_tx_ready = 1'b1;
      clear_inputs();
      repeat (2) @(posedge i_clk);
      #1;
      check_eq("rst_valid", o_tx_valid, 0);
      check_eq("rst_data", o_tx_data, 0);
      check_eq("rst_busy", o_busy, 0);
      check_eq("rst_done", o_done, 0);
      i_reset = 1'b0;
      cycle();

      // All-zero frame; busy must last exactly one cycle per byte.
      start_frame();
      n = 0;
      while (o_busy && n < 100) begin
         n++;
         cycle();
      end
      check_eq("busy_cycles", n, 32);
      wait_idle();
      check_eq("zero_checksum", last_byte, 8'h00);

      clear_inputs();
      i_bus_a = 32'h12345678;
      start_frame();
      wait_idle();
      check_eq("bus_a_checksum", last_byte, 8'h08);

      clear_inputs();
      i_mem_rd_src = 3'b101; i_alu_op = 3'b011; i_rs = 5'd31; i_funct = 6'h20;
      start_frame();
      wait_idle();
      check_eq("ctrl_checksum", last_byte, 8'h9C);

      // Random contents under random backpressure.
      rdy_rand = 1'b1;
      for (int f = 0; f < 3; f++) begin
         random_inputs();
         start_frame();
         wait_idle();
      end
      rdy_rand = 1'b0;
      i_tx_ready = 1'b1;
      cycle();

      // Stall at byte 4 while the latch inputs keep changing.
      random_inputs();
      base = xfer_cnt;
      start_frame();
      wait_bytes(base, 4);
      i_tx_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         random_inputs();
         cycle();
      end
      i_tx_ready = 1'b1;
      wait_idle();

      // Start pulses during a frame must not queue a second one.
      random_inputs();
      start_frame();
      for (int k = 0; k < 5; k++) begin
         i_start = 1'b1;
         cycle();
         i_start = 1'b0;
         cycle();
      end
      wait_idle();
      repeat (3) cycle();
      check_eq("no_queued_frame", o_busy, 0);

      // Held start: two frames with one idle cycle between them.
      random_inputs();
      base = xfer_cnt;
      i_start = 1'b1;
      push_frame();
      push_frame();
      cycle();
      wait_bytes(base, 32);
      n = 0;
      while (!o_tx_valid && n < 10) begin
         n++;
         cycle();
      end
      check_eq("b2b_gap", n, 1);
      i_start = 1'b0;
      wait_idle();

      // Reset at byte 10 aborts the frame immediately.
      random_inputs();
      base = xfer_cnt;
      start_frame();
      wait_bytes(base, 10);
      i_reset = 1'b1;
      #1;
      check_eq("abort_valid", o_tx_valid, 0);
      check_eq("abort_busy", o_busy, 0);
      check_eq("abort_data", o_tx_data, 0);
      check_eq("abort_done", o_done, 0);
      cycle();
      i_reset = 1'b0;
      repeat (4) cycle();
      check_eq("post_abort_idle", o_busy, 0);
      random_inputs();
      start_frame();
      wait_idle();

      repeat (2) cycle();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/id_ex_dump.md
ID_EX_DUMP -- requirements
Module: id_ex_dump

Interface
REQ-001 SHALL have parameter BUS_SIZE, default 32, data field width; multiple of 8; B = BUS_SIZE/8.
REQ-002 SHALL have i_clk  in  1  clock; all state changes on rising edge.
REQ-003 SHALL have i_reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have i_start  in  1  snapshot-and-send request, sampled only in IDLE.
REQ-005 SHALL have i_mem_rd_src/i_mem_wr_src/i_mem_write/i_wb/i_mem_to_reg/i_reg_dst/i_alu_src_a/i_alu_src_b/i_alu_op  in  3/2/1/1/1/2/1/2/3  ID/EX latch control outputs.
REQ-006 SHALL have i_bus_a, i_bus_b  in  BUS_SIZE each  ID/EX operand buses.
REQ-007 SHALL have i_rs, i_rt, i_rd, i_funct  in  5/5/5/6  ID/EX register/funct fields.
REQ-008 SHALL have i_shamt_ext_unsigned, i_inm_ext_signed, i_inm_upp, i_inm_ext_unsigned  in  BUS_SIZE each  ID/EX immediates.
REQ-009 SHALL have o_tx_data  out  8  byte to UART transmitter.
REQ-010 SHALL have o_tx_valid  out  1  o_tx_data valid; i_tx_ready  in  1  transmitter accepts.
REQ-011 SHALL have o_busy  out  1  frame in progress; o_done  out  1  one-cycle frame-complete pulse.

Function
REQ-012 SHALL implement FSM IDLE -> SEND -> IDLE; no other states reachable.
REQ-013 In IDLE, edge with i_start=1 SHALL capture all REQ-005..008 inputs into a snapshot, clear byte index and checksum, go SEND.
REQ-014 Snapshot SHALL remain constant for whole frame regardless of input changes.
REQ-015 Control word SHALL be 16 bits: [15:13] mem_rd_src, [12:11] mem_wr_src, [10] mem_write, [9] wb, [8] mem_to_reg, [7:6] reg_dst, [5] alu_src_a, [4:3] alu_src_b, [2:0] alu_op.
REQ-016 Frame SHALL be 8+6B bytes (32 at default), index order: 0 = 0xA5; 1,2 = ctrl[15:8],ctrl[7:0]; then bus_a, bus_b (B bytes each, MSB first); {3'b0,rs}; {3'b0,rt}; {3'b0,rd}; {2'b0,funct}; then shamt, inm_signed, inm_upp, inm_unsigned (B bytes each, MSB first); last = checksum.
REQ-017 Checksum SHALL be XOR of all bytes between header and checksum (indices 1..6+6B), header excluded.
REQ-018 In SEND, o_tx_valid SHALL be 1 continuously, first asserted the cycle after the capture edge.
REQ-019 A byte SHALL transfer on an edge with o_tx_valid=1 and i_tx_ready=1; index increments by one per transfer.
REQ-020 While i_tx_ready=0, o_tx_data and index SHALL hold; no byte skipped or duplicated.
REQ-021 Transfer of last (checksum) byte SHALL return FSM to IDLE, drop o_tx_valid, pulse o_done for exactly the following cycle.
REQ-022 o_busy SHALL equal (state==SEND); i_start while busy SHALL be ignored, not queued.
REQ-023 i_start high continuously SHALL start a new frame on the first IDLE edge after o_done, i.e. frames back-to-back with one idle cycle.
REQ-024 o_tx_data SHALL be 0x00 whenever o_tx_valid=0.

Reset
REQ-025 i_reset=1 SHALL immediately force IDLE, index 0, checksum 0, snapshot 0, o_tx_data=0x00, o_tx_valid=0, o_busy=0, o_done=0.
REQ-026 Reset mid-frame SHALL abort the frame; no further bytes until a new i_start after reset release.

Verification
REQ-027 All inputs 0, i_start pulse, ready=1 -> 32 bytes: 0xA5, thirty 0x00, checksum 0x00; o_done one cycle after last; o_busy high 32 cycles.
REQ-028 bus_a=0x12345678, others 0 -> bytes 3..6 = 12 34 56 78, checksum 0x08.
REQ-029 mem_rd_src=3'b101, alu_op=3'b011, rs=5'd31, funct=6'h20, others 0 -> bytes 1,2 = 0xA0,0x03; byte 11 = 0x1F; byte 14 = 0x20; checksum 0xA0^0x03^0x1F^0x20 = 0x9C.
REQ-030 i_tx_ready low 5 cycles at index 4, inputs changed meanwhile -> o_tx_data held, frame identical to snapshot at start.
REQ-031 i_start pulses while busy -> ignored, exactly one 32-byte frame; i_start held high -> back-to-back frames, one idle cycle between.
REQ-032 i_reset asserted at index 10 -> o_tx_valid=0 same cycle, o_busy=0; next i_start sends full frame from 0xA5.
